// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared Game of Life scheduler state type and grid defaults
package gol_pkg;

   localparam int GOL_ROWS = 16;
   localparam int GOL_COLS = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_TICK,
      S_ROW_START,
      S_ROW_WAIT,
      S_SWAP
   } gen_state_t;

endpackage

// File: rtl/gol_tick_div.sv
// rtl/gol_tick_div.sv - generation tick divider, held at zero while disabled
module gol_tick_div
   import gol_pkg::*;
#(
   parameter int TICK_DIV = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == CW'(TICK_DIV - 1));
   assign tick   = en & w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!en || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/gol_gen_sched.sv
// rtl/gol_gen_sched.sv - Game of Life generation scheduler
// Issues one row job per engine handshake, swaps buffers per generation, owns the host write port.
module gol_gen_sched
   import gol_pkg::*;
#(
   parameter int ROWS     = GOL_ROWS,
   parameter int COLS     = GOL_COLS,
   parameter int TICK_DIV = 1000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic                    run,
   input  logic                    reset,
   input  logic                    ld_we,
   input  logic [$clog2(ROWS)-1:0] ld_row,
   input  logic [COLS-1:0]         ld_data,
   output logic                    mem_we,
   output logic                    mem_buf,
   output logic [$clog2(ROWS)-1:0] mem_row,
   output logic [COLS-1:0]         mem_data,
   output logic                    eng_start,
   output logic [$clog2(ROWS)-1:0] eng_row,
   output logic                    eng_src,
   input  logic                    eng_done,
   output logic                    cur_buf,
   output logic [15:0]             gen_count,
   output logic                    gen_done,
   output logic                    busy,
   output logic                    overrun
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(2 * ROWS);

   gen_state_t    r_state;
   gen_state_t    w_next;
   logic          r_reset_q;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_clr_idx;
   logic          r_cur_buf;
   logic [15:0]   r_gen_count;
   logic          r_overrun;

   logic w_tick;
   logic w_tick_en;
   logic w_reset_edge;
   logic w_row_last;
   logic w_clr_last;
   logic w_clr_hi;
   logic w_in_gen;

   assign w_tick_en    = run & (r_state != S_IDLE) & (r_state != S_CLEAR);
   assign w_reset_edge = reset & ~r_reset_q;
   assign w_row_last   = (r_row == RW'(ROWS - 1));
   assign w_clr_last   = (r_clr_idx == CW'(2 * ROWS - 1));
   assign w_clr_hi     = (r_clr_idx >= CW'(ROWS));
   assign w_in_gen     = (r_state == S_ROW_START) | (r_state == S_ROW_WAIT) | (r_state == S_SWAP);

   gol_tick_div #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_div (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (w_tick_en),
      .tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_we    = 1'b0;
      mem_buf   = 1'b0;
      mem_row   = '0;
      mem_data  = '0;
      eng_start = 1'b0;
      gen_done  = 1'b0;
      busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy     = 1'b0;
            mem_we   = load & ld_we;
            mem_buf  = r_cur_buf;
            mem_row  = ld_row;
            mem_data = ld_data;
            if (w_reset_edge) begin
               w_next = S_CLEAR;
            end else if (run) begin
               w_next = S_WAIT_TICK;
            end
         end
         S_CLEAR: begin
            // Buffer 0 rows first, then buffer 1; data stays zero.
            mem_we  = 1'b1;
            mem_buf = w_clr_hi;
            mem_row = w_clr_hi ? RW'(r_clr_idx - CW'(ROWS)) : RW'(r_clr_idx);
            if (w_clr_last) begin
               w_next = S_IDLE;
            end
         end
         S_WAIT_TICK: begin
            busy = 1'b0;
            if (!run) begin
               w_next = S_IDLE;
            end else if (w_tick) begin
               w_next = S_ROW_START;
            end
         end
         S_ROW_START: begin
            eng_start = 1'b1;
            w_next    = S_ROW_WAIT;
         end
         S_ROW_WAIT: begin
            if (eng_done) begin
               w_next = w_row_last ? S_SWAP : S_ROW_START;
            end
         end
         S_SWAP: begin
            gen_done = 1'b1;
            w_next   = run ? S_WAIT_TICK : S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reset_q   <= 1'b0;
         r_row       <= '0;
         r_clr_idx   <= '0;
         r_cur_buf   <= 1'b0;
         r_gen_count <= '0;
         r_overrun   <= 1'b0;
      end else begin
         // Tracked in every state, so an edge seen mid-generation is consumed.
         r_reset_q <= reset;

         if (r_state == S_WAIT_TICK && w_tick) begin
            r_row <= '0;
         end else if (r_state == S_ROW_WAIT && eng_done && !w_row_last) begin
            r_row <= r_row + 1'b1;
         end

         if (r_state == S_CLEAR) begin
            r_clr_idx <= w_clr_last ? '0 : r_clr_idx + 1'b1;
         end

         if (r_state == S_SWAP) begin
            r_cur_buf   <= ~r_cur_buf;
            r_gen_count <= r_gen_count + 16'd1;
         end else if (r_state == S_CLEAR && w_clr_last) begin
            r_cur_buf   <= 1'b0;
            r_gen_count <= '0;
         end

         if (r_state == S_CLEAR && w_clr_last) begin
            r_overrun <= 1'b0;
         end else if (w_tick && w_in_gen) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign eng_row   = r_row;
   assign eng_src   = r_cur_buf;
   assign cur_buf   = r_cur_buf;
   assign gen_count = r_gen_count;
   assign overrun   = r_overrun;

endmodule
